// File: rtl/compare_pkg.sv
// Shared types and default parameters for the threshold comparator.
package compare_pkg;

    typedef enum logic [1:0] {
        CMP_GT = 2'b00,
        CMP_GE = 2'b01,
        CMP_LT = 2'b10,
        CMP_EQ = 2'b11
    } cmp_mode_t;

    localparam int unsigned DEF_WIDTH    = 10;
    localparam int unsigned DEF_CHANNELS = 4;
    localparam int unsigned DEF_HOLD     = 3;

endpackage

// File: rtl/compare_channel.sv
// One channel: compare against threshold, saturating run counter, debounced flag.
module compare_channel
    import compare_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned HOLD  = DEF_HOLD
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             accept,
    input  logic             restart,
    input  logic             clear,
    input  cmp_mode_t        mode,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] threshold,
    output logic             hit,
    output logic             flag,
    output logic             flag_set_c
);

    localparam int unsigned CW = $clog2(HOLD + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_base;
    logic [CW-1:0] cnt_nxt;
    logic          cmp_c;

    // Compare, then advance the run counter; a mode change restarts the run.
    always_comb begin
        cmp_c    = 1'b0;
        cnt_base = cnt_q;
        cnt_nxt  = '0;
        case (mode)
            CMP_GT:  cmp_c = sample >  threshold;
            CMP_GE:  cmp_c = sample >= threshold;
            CMP_LT:  cmp_c = sample <  threshold;
            CMP_EQ:  cmp_c = sample == threshold;
            default: cmp_c = 1'b0;
        endcase
        if (restart) begin
            cnt_base = '0;
        end
        if (cmp_c) begin
            cnt_nxt = (cnt_base == CW'(HOLD)) ? CW'(HOLD) : cnt_base + CW'(1);
        end
    end

    assign flag_set_c = accept & (cnt_nxt == CW'(HOLD));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            hit   <= 1'b0;
            flag  <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            hit   <= 1'b0;
            flag  <= 1'b0;
        end else if (accept) begin
            cnt_q <= cnt_nxt;
            hit   <= cmp_c;
            flag  <= (cnt_nxt == CW'(HOLD));
        end
    end

endmodule

// File: rtl/threshold_compare.sv
// Multi-channel threshold comparator with debounced flags, sticky summary and max tracking.
module threshold_compare
    import compare_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEF_WIDTH,
    parameter  int unsigned CHANNELS = DEF_CHANNELS,
    parameter  int unsigned HOLD     = DEF_HOLD,
    localparam int unsigned IDXW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] sample,
    input  logic [WIDTH-1:0]          threshold,
    input  logic [1:0]                mode,
    input  logic                      clear,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       hit,
    output logic [CHANNELS-1:0]       flag,
    output logic                      sticky,
    output logic [WIDTH-1:0]          max_val,
    output logic [IDXW-1:0]           max_idx
);

    cmp_mode_t           mode_c;
    cmp_mode_t           mode_q;
    logic                accept_c;
    logic                restart_c;
    logic [CHANNELS-1:0] flag_set_c;
    logic [WIDTH-1:0]    best_val_c;
    logic [IDXW-1:0]     best_idx_c;

    assign mode_c    = cmp_mode_t'(mode);
    assign accept_c  = in_valid & ~clear;
    assign restart_c = accept_c & (mode_c != mode_q);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        compare_channel #(
            .WIDTH (WIDTH),
            .HOLD  (HOLD)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .accept     (accept_c),
            .restart    (restart_c),
            .clear      (clear),
            .mode       (mode_c),
            .sample     (sample[i*WIDTH +: WIDTH]),
            .threshold  (threshold),
            .hit        (hit[i]),
            .flag       (flag[i]),
            .flag_set_c (flag_set_c[i])
        );
    end

    // Largest sample this cycle; strict compare keeps the lowest index on ties.
    always_comb begin
        best_val_c = sample[WIDTH-1:0];
        best_idx_c = '0;
        for (int i = 1; i < int'(CHANNELS); i++) begin
            if (sample[i*WIDTH +: WIDTH] > best_val_c) begin
                best_val_c = sample[i*WIDTH +: WIDTH];
                best_idx_c = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            mode_q    <= CMP_GT;
            sticky    <= 1'b0;
            max_val   <= '0;
            max_idx   <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            sticky    <= 1'b0;
            max_val   <= '0;
            max_idx   <= '0;
        end else begin
            out_valid <= accept_c;
            if (accept_c) begin
                mode_q <= mode_c;
                if (best_val_c > max_val) begin
                    max_val <= best_val_c;
                    max_idx <= best_idx_c;
                end
            end
            if (|flag_set_c) begin
                sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_threshold_compare.sv
// Self-checking bench for threshold_compare: directed cases plus randomized traffic vs a behavioural model.
module tb_threshold_compare;
    import compare_pkg::*;

    localparam int unsigned W    = 10;
    localparam int unsigned CH   = 4;
    localparam int unsigned HOLD = 3;
    localparam int unsigned IW   = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [CH*W-1:0]   sample;
    logic [W-1:0]      threshold;
    logic [1:0]        mode;
    logic              clear;
    logic              out_valid;
    logic [CH-1:0]     hit;
    logic [CH-1:0]     flag;
    logic              sticky;
    logic [W-1:0]      max_val;
    logic [IW-1:0]     max_idx;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    int          m_cnt [CH];
    logic [1:0]  m_mode;
    logic        m_ov;
    logic [CH-1:0] m_hit;
    logic [CH-1:0] m_flag;
    logic        m_sticky;
    int          m_max;
    int          m_idx;

    threshold_compare #(.WIDTH(W), .CHANNELS(CH), .HOLD(HOLD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .sample    (sample),
        .threshold (threshold),
        .mode      (mode),
        .clear     (clear),
        .out_valid (out_valid),
        .hit       (hit),
        .flag      (flag),
        .sticky    (sticky),
        .max_val   (max_val),
        .max_idx   (max_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit cmp_ref(input int s, input int t, input logic [1:0] md);
        case (md)
            2'b00:   return s > t;
            2'b01:   return s >= t;
            2'b10:   return s < t;
            default: return s == t;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(CH); i++) m_cnt[i] = 0;
        m_mode = 2'b00; m_ov = 1'b0; m_hit = '0; m_flag = '0;
        m_sticky = 1'b0; m_max = 0; m_idx = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(CH); i++) m_cnt[i] = 0;
        m_ov = 1'b0; m_hit = '0; m_flag = '0;
        m_sticky = 1'b0; m_max = 0; m_idx = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        check({tag, ".hit"},       64'(hit),       64'(m_hit));
        check({tag, ".flag"},      64'(flag),      64'(m_flag));
        check({tag, ".sticky"},    64'(sticky),    64'(m_sticky));
        check({tag, ".max_val"},   64'(max_val),   64'(m_max));
        check({tag, ".max_idx"},   64'(max_idx),   64'(m_idx));
    endtask

    // One clock: drive after a negedge, let the model advance, compare at the next negedge.
    task automatic step(input string tag, input bit v, input int s0, input int s1, input int s2,
                        input int s3, input int thr, input logic [1:0] md, input bit clr);
        int s [CH];
        s = '{s0, s1, s2, s3};
        in_valid  = v;
        sample    = {W'(s3), W'(s2), W'(s1), W'(s0)};
        threshold = W'(thr);
        mode      = md;
        clear     = clr;
        @(posedge clk);
        if (clr) begin
            model_clear();
        end else if (v) begin
            m_ov = 1'b1;
            if (md != m_mode) begin
                for (int i = 0; i < int'(CH); i++) m_cnt[i] = 0;
            end
            m_mode = md;
            for (int i = 0; i < int'(CH); i++) begin
                if (cmp_ref(s[i], thr, md)) begin
                    m_cnt[i] = (m_cnt[i] + 1 > int'(HOLD)) ? int'(HOLD) : m_cnt[i] + 1;
                    m_hit[i] = 1'b1;
                end else begin
                    m_cnt[i] = 0;
                    m_hit[i] = 1'b0;
                end
                m_flag[i] = (m_cnt[i] == int'(HOLD));
                if (m_flag[i]) m_sticky = 1'b1;
            end
            for (int i = 0; i < int'(CH); i++) begin
                if (s[i] > m_max) begin
                    m_max = s[i];
                    m_idx = i;
                end
            end
        end else begin
            m_ov = 1'b0;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [1:0] rmode;
        int thr;
        int rs [CH];

        reset_n = 1'b0; in_valid = 1'b0; sample = '0; threshold = '0; mode = 2'b00; clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // ch0 above threshold three times in GT, then exactly at threshold
        step("gt1", 1, 101, 0, 0, 0, 100, 2'b00, 0);
        step("gt2", 1, 101, 0, 0, 0, 100, 2'b00, 0);
        check("gt2.flag0_low", 64'(flag[0]), 64'd0);
        step("gt3", 1, 101, 0, 0, 0, 100, 2'b00, 0);
        check("gt3.flag0", 64'(flag[0]), 64'd1);
        check("gt3.sticky", 64'(sticky), 64'd1);
        step("gt_eq", 1, 100, 0, 0, 0, 100, 2'b00, 0);
        check("gt_eq.flag0", 64'(flag[0]), 64'd0);
        check("gt_eq.hit0", 64'(hit[0]), 64'd0);
        check("gt_eq.sticky", 64'(sticky), 64'd1);

        // ch1 run interrupted by idle cycles still counts accepted samples only
        step("gap1", 1, 0, 200, 0, 0, 100, 2'b00, 0);
        step("gap2", 1, 0, 200, 0, 0, 100, 2'b00, 0);
        for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0, 0, 0, 2'b00, 0);
        check("idle.flag1", 64'(flag[1]), 64'd0);
        check("idle.out_valid", 64'(out_valid), 64'd0);
        step("gap3", 1, 0, 200, 0, 0, 100, 2'b00, 0);
        check("gap3.flag1", 64'(flag[1]), 64'd1);
        check("gap3.out_valid", 64'(out_valid), 64'd1);

        // all-ones boundary in each mode
        step("eq_max", 1, 1023, 1023, 1023, 1023, 1023, 2'b11, 0);
        check("eq_max.hit", 64'(hit), 64'hF);
        step("ge_max", 1, 1023, 1023, 1023, 1023, 1023, 2'b01, 0);
        check("ge_max.hit", 64'(hit), 64'hF);
        step("gt_max", 1, 1023, 1023, 1023, 1023, 1023, 2'b00, 0);
        check("gt_max.hit", 64'(hit), 64'h0);
        step("lt_max", 1, 1023, 1023, 1023, 1023, 1023, 2'b10, 0);
        check("lt_max.hit", 64'(hit), 64'h0);

        // mode change mid-run restarts the count
        step("mc1", 1, 5, 5, 5, 5, 0, 2'b01, 0);
        step("mc2", 1, 5, 5, 5, 5, 0, 2'b01, 0);
        step("mc3", 1, 5, 5, 5, 5, 0, 2'b00, 0);
        step("mc4", 1, 5, 5, 5, 5, 0, 2'b00, 0);
        check("mc4.flag", 64'(flag), 64'h0);
        step("mc5", 1, 5, 5, 5, 5, 0, 2'b00, 0);
        check("mc5.flag", 64'(flag), 64'hF);

        // max tracking with tie and non-strict repeat
        step("clr0", 1, 7, 7, 7, 7, 0, 2'b00, 1);
        check("clr0.out_valid", 64'(out_valid), 64'd0);
        check("clr0.max_val", 64'(max_val), 64'd0);
        step("mx1", 1, 5, 900, 900, 3, 1000, 2'b00, 0);
        check("mx1.max_val", 64'(max_val), 64'd900);
        check("mx1.max_idx", 64'(max_idx), 64'd1);
        step("mx2", 1, 900, 0, 0, 0, 1000, 2'b00, 0);
        check("mx2.max_idx", 64'(max_idx), 64'd1);

        // clear with simultaneous valid, then async reset mid-run
        step("pre1", 1, 600, 600, 600, 600, 500, 2'b00, 0);
        step("pre2", 1, 600, 600, 600, 600, 500, 2'b00, 0);
        step("pre3", 1, 600, 600, 600, 600, 500, 2'b00, 0);
        step("clr1", 1, 600, 600, 600, 600, 500, 2'b00, 1);
        check("clr1.all", 64'({out_valid, hit, flag, sticky, max_val, max_idx}), 64'd0);
        step("r1", 1, 600, 0, 0, 0, 500, 2'b00, 0);
        step("r2", 1, 600, 0, 0, 0, 500, 2'b00, 0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        step("ar1", 1, 600, 0, 0, 0, 500, 2'b00, 0);
        step("ar2", 1, 600, 0, 0, 0, 500, 2'b00, 0);
        check("ar2.flag0", 64'(flag[0]), 64'd0);
        step("ar3", 1, 600, 0, 0, 0, 500, 2'b00, 0);
        check("ar3.flag0", 64'(flag[0]), 64'd1);

        // randomized traffic near the threshold
        rmode = 2'b00;
        thr = 512;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) rmode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) thr = int'($urandom_range(0, 1023));
            for (int i = 0; i < int'(CH); i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    rs[i] = int'($urandom_range(0, 1023));
                end else begin
                    rs[i] = thr + int'($urandom_range(0, 4)) - 2;
                    if (rs[i] < 0) rs[i] = 0;
                    if (rs[i] > 1023) rs[i] = 1023;
                end
            end
            step("rnd", ($urandom_range(0, 9) < 7), rs[0], rs[1], rs[2], rs[3], thr, rmode,
                 ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
